// File: rtl/snake_pkg.sv
// Shared snake-game constants: coordinate widths, playfield bounds and the placer FSM states.
package snake_pkg;

   localparam int unsigned X_W = 8;
   localparam int unsigned Y_W = 7;

   localparam logic [X_W-1:0] X_MIN = 8'd15;
   localparam logic [X_W-1:0] X_MAX = 8'd130;
   localparam logic [Y_W-1:0] Y_MIN = 7'd15;
   localparam logic [Y_W-1:0] Y_MAX = 7'd100;

   typedef enum logic [1:0] {
      StIdle,
      StSample,
      StScan,
      StPlace
   } state_e;

   function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
   endfunction

endpackage

// File: rtl/food_placer.sv
// Food placer: draws RNG candidates and scans the snake body RAM until a free cell is found
// or the draw budget runs out.
module food_placer
   import snake_pkg::*;
#(
   parameter int unsigned MAX_LEN   = 64,
   parameter int unsigned MAX_TRIES = 16,
   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
   localparam int unsigned TW = $clog2(MAX_TRIES + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_place_req,
   input  logic [X_W-1:0] i_rng_x,
   input  logic [Y_W-1:0] i_rng_y,
   input  logic [AW:0]    i_snake_len,
   output logic [AW-1:0]  o_body_addr,
   input  logic [X_W-1:0] i_body_x,
   input  logic [Y_W-1:0] i_body_y,
   output logic [X_W-1:0] o_food_x,
   output logic [Y_W-1:0] o_food_y,
   output logic           o_food_valid,
   output logic           o_busy,
   output logic           o_place_fail
);

   state_e         r_state,  w_state_nxt;
   logic [X_W-1:0] r_cand_x, w_cand_x_nxt;
   logic [Y_W-1:0] r_cand_y, w_cand_y_nxt;
   logic [TW-1:0]  r_tries,  w_tries_nxt;
   logic [AW-1:0]  r_addr,   w_addr_nxt;
   logic [AW-1:0]  r_idx,    w_idx_nxt;
   logic [X_W-1:0] r_food_x, w_food_x_nxt;
   logic [Y_W-1:0] r_food_y, w_food_y_nxt;
   logic           r_valid,  w_valid_nxt;
   logic           r_fail,   w_fail_nxt;

   logic [TW-1:0]  w_tries_inc;
   logic [AW:0]    w_len_m1;
   logic           w_hit;
   logic           w_last;

   assign w_tries_inc = r_tries + TW'(1);
   assign w_len_m1    = i_snake_len - (AW + 1)'(1);
   assign w_hit       = (i_body_x == r_cand_x) && (i_body_y == r_cand_y);
   // r_idx names the segment whose data is on the body bus this cycle (one behind r_addr).
   assign w_last      = ({1'b0, r_idx} == w_len_m1);

   always_comb begin
      w_state_nxt  = r_state;
      w_cand_x_nxt = r_cand_x;
      w_cand_y_nxt = r_cand_y;
      w_tries_nxt  = r_tries;
      w_addr_nxt   = r_addr;
      w_idx_nxt    = r_idx;
      w_food_x_nxt = r_food_x;
      w_food_y_nxt = r_food_y;
      w_valid_nxt  = r_valid;
      w_fail_nxt   = 1'b0;

      case (r_state)
         StIdle: begin
            if (i_place_req) begin
               w_state_nxt = StSample;
               w_valid_nxt = 1'b0;
               w_tries_nxt = '0;
               w_addr_nxt  = '0;
            end
         end

         StSample: begin
            w_cand_x_nxt = i_rng_x;
            w_cand_y_nxt = i_rng_y;
            w_tries_nxt  = w_tries_inc;
            w_idx_nxt    = '0;
            w_addr_nxt   = '0;
            if (!in_bounds(i_rng_x, i_rng_y)) begin
               if (w_tries_inc < TW'(MAX_TRIES)) begin
                  w_state_nxt = StSample;
               end else begin
                  w_state_nxt = StIdle;
                  w_fail_nxt  = 1'b1;
                  w_valid_nxt = 1'b0;
               end
            end else if (i_snake_len == '0) begin
               w_state_nxt = StPlace;
            end else begin
               // Address 0 was presented during this cycle, so the scan resumes at 1.
               w_state_nxt = StScan;
               w_addr_nxt  = (i_snake_len > (AW + 1)'(1)) ? AW'(1) : '0;
            end
         end

         StScan: begin
            if (w_hit) begin
               w_addr_nxt = '0;
               if (r_tries < TW'(MAX_TRIES)) begin
                  w_state_nxt = StSample;
               end else begin
                  w_state_nxt = StIdle;
                  w_fail_nxt  = 1'b1;
                  w_valid_nxt = 1'b0;
               end
            end else if (w_last) begin
               w_state_nxt = StPlace;
               w_addr_nxt  = '0;
            end else begin
               w_idx_nxt  = r_idx + AW'(1);
               w_addr_nxt = ({1'b0, r_addr} < w_len_m1) ? r_addr + AW'(1) : r_addr;
            end
         end

         StPlace: begin
            w_food_x_nxt = r_cand_x;
            w_food_y_nxt = r_cand_y;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = StIdle;
         end

         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_cand_x <= '0;
         r_cand_y <= '0;
         r_tries  <= '0;
         r_addr   <= '0;
         r_idx    <= '0;
         r_food_x <= '0;
         r_food_y <= '0;
         r_valid  <= 1'b0;
         r_fail   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cand_x <= w_cand_x_nxt;
         r_cand_y <= w_cand_y_nxt;
         r_tries  <= w_tries_nxt;
         r_addr   <= w_addr_nxt;
         r_idx    <= w_idx_nxt;
         r_food_x <= w_food_x_nxt;
         r_food_y <= w_food_y_nxt;
         r_valid  <= w_valid_nxt;
         r_fail   <= w_fail_nxt;
      end
   end

   assign o_body_addr  = r_addr;
   assign o_food_x     = r_food_x;
   assign o_food_y     = r_food_y;
   assign o_food_valid = r_valid;
   assign o_busy       = (r_state != StIdle);
   assign o_place_fail = r_fail;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer: body RAM model with one-cycle read latency and
// hand-computed placement timing.
module tb_food_placer;

   localparam int unsigned MAX_LEN   = 8;
   localparam int unsigned MAX_TRIES = 4;

   logic       clk;
   logic       rst_n;
   logic       place_req;
   logic [7:0] rng_x;
   logic [6:0] rng_y;
   logic [3:0] snake_len;
   logic [2:0] body_addr;
   logic [7:0] body_x;
   logic [6:0] body_y;
   logic [7:0] food_x;
   logic [6:0] food_y;
   logic       food_valid;
   logic       busy;
   logic       place_fail;

   logic [7:0] ram_x [MAX_LEN];
   logic [6:0] ram_y [MAX_LEN];

   int n_pass  = 0;
   int n_total = 0;

   food_placer #(
      .MAX_LEN  (MAX_LEN),
      .MAX_TRIES(MAX_TRIES)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_place_req (place_req),
      .i_rng_x     (rng_x),
      .i_rng_y     (rng_y),
      .i_snake_len (snake_len),
      .o_body_addr (body_addr),
      .i_body_x    (body_x),
      .i_body_y    (body_y),
      .o_food_x    (food_x),
      .o_food_y    (food_y),
      .o_food_valid(food_valid),
      .o_busy      (busy),
      .o_place_fail(place_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read body RAM: data appears the cycle after the address.
   always @(posedge clk) begin
      body_x <= ram_x[body_addr];
      body_y <= ram_y[body_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 ns after E0, the edge that samples the request.
   task automatic pulse_req();
      place_req = 1'b1;
      tick();
      place_req = 1'b0;
   endtask

   task automatic load_body(input logic [7:0] x0, input logic [6:0] y0,
                            input logic [7:0] x1, input logic [6:0] y1,
                            input logic [7:0] x2, input logic [6:0] y2);
      ram_x[0] = x0; ram_y[0] = y0;
      ram_x[1] = x1; ram_y[1] = y1;
      ram_x[2] = x2; ram_y[2] = y2;
   endtask

   initial begin
      int n_fail_pulse;
      int fail_at;

      for (int i = 0; i < int'(MAX_LEN); i++) begin
         ram_x[i] = 8'd0;
         ram_y[i] = 7'd0;
      end
      rst_n     = 1'b0;
      place_req = 1'b0;
      rng_x     = 8'd40;
      rng_y     = 7'd30;
      snake_len = 4'd0;
      #12;
      check("rst_food_x", 32'(food_x), 0);
      check("rst_food_y", 32'(food_y), 0);
      check("rst_valid", 32'(food_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_fail", 32'(place_fail), 0);
      check("rst_addr", 32'(body_addr), 0);
      rst_n = 1'b1;
      tick();

      // Empty snake: placement two edges after the request.
      pulse_req();
      check("len0_busy_e0", 32'(busy), 1);
      check("len0_valid_e0", 32'(food_valid), 0);
      tick();
      check("len0_valid_e1", 32'(food_valid), 0);
      tick();
      check("len0_valid_e2", 32'(food_valid), 1);
      check("len0_food_x", 32'(food_x), 40);
      check("len0_food_y", 32'(food_y), 30);
      check("len0_busy_e2", 32'(busy), 0);

      // Three segments, free candidate: placement at E0+5.
      load_body(8'd10, 7'd10, 8'd11, 7'd10, 8'd12, 7'd10);
      snake_len = 4'd3;
      rng_x = 8'd50;
      rng_y = 7'd50;
      pulse_req();
      check("len3_valid_drop", 32'(food_valid), 0);
      check("len3_food_hold", 32'(food_x), 40);
      tick(); tick(); tick();
      check("len3_addr_hold", 32'(body_addr), 2);
      tick();
      check("len3_valid_e4", 32'(food_valid), 0);
      tick();
      check("len3_valid_e5", 32'(food_valid), 1);
      check("len3_food_x", 32'(food_x), 50);
      check("len3_food_y", 32'(food_y), 50);

      // Segment 1 collides with the first draw; the second draw lands at E0+8.
      load_body(8'd10, 7'd10, 8'd50, 7'd50, 8'd12, 7'd10);
      rng_x = 8'd50;
      rng_y = 7'd50;
      pulse_req();
      check("retry_food_hold", 32'(food_x), 50);
      tick();
      rng_x = 8'd60;
      rng_y = 7'd20;
      for (int i = 2; i <= 7; i++) tick();
      check("retry_valid_e7", 32'(food_valid), 0);
      check("retry_busy_e7", 32'(busy), 1);
      tick();
      check("retry_valid_e8", 32'(food_valid), 1);
      check("retry_food_x", 32'(food_x), 60);
      check("retry_food_y", 32'(food_y), 20);

      // Every draw collides: four draws, then a single fail pulse at E0+8.
      load_body(8'd50, 7'd50, 8'd50, 7'd50, 8'd50, 7'd50);
      rng_x = 8'd50;
      rng_y = 7'd50;
      pulse_req();
      n_fail_pulse = 0;
      fail_at      = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (place_fail) begin
            n_fail_pulse++;
            fail_at = i;
         end
      end
      check("fail_pulse_count", 32'(n_fail_pulse), 1);
      check("fail_pulse_edge", 32'(fail_at), 8);
      check("fail_valid", 32'(food_valid), 0);
      check("fail_busy", 32'(busy), 0);
      check("fail_food_hold", 32'(food_x), 60);

      // Out-of-range X is rejected in SAMPLE; the next draw scans and lands at E0+6.
      load_body(8'd10, 7'd10, 8'd11, 7'd10, 8'd12, 7'd10);
      rng_x = 8'd140;
      rng_y = 7'd50;
      pulse_req();
      tick();
      rng_x = 8'd70;
      rng_y = 7'd40;
      check("oob_busy_e1", 32'(busy), 1);
      for (int i = 2; i <= 5; i++) tick();
      check("oob_valid_e5", 32'(food_valid), 0);
      tick();
      check("oob_valid_e6", 32'(food_valid), 1);
      check("oob_food_x", 32'(food_x), 70);
      check("oob_food_y", 32'(food_y), 40);

      // A second request mid-scan is ignored; the original candidate completes at E0+5.
      rng_x = 8'd80;
      rng_y = 7'd60;
      pulse_req();
      tick(); tick();
      place_req = 1'b1;
      rng_x = 8'd90;
      rng_y = 7'd90;
      tick();
      place_req = 1'b0;
      tick(); tick();
      check("ignore_valid_e5", 32'(food_valid), 1);
      check("ignore_food_x", 32'(food_x), 80);
      check("ignore_food_y", 32'(food_y), 60);
      tick();
      check("ignore_idle_e6", 32'(busy), 0);
      check("ignore_valid_e6", 32'(food_valid), 1);

      // Reset mid-scan clears everything at once and nothing is placed afterwards.
      rng_x = 8'd33;
      rng_y = 7'd33;
      pulse_req();
      tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_valid", 32'(food_valid), 0);
      check("arst_food_x", 32'(food_x), 0);
      check("arst_food_y", 32'(food_y), 0);
      check("arst_addr", 32'(body_addr), 0);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("arst_no_place_valid", 32'(food_valid), 0);
      check("arst_no_place_busy", 32'(busy), 0);
      check("arst_no_place_x", 32'(food_x), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
